// File: rtl/framebuffer_reader_if.sv
// Framebuffer read port plus the x/y-tagged pixel stream built from it.
// master = scan engine side, slave = framebuffer memory and display side.
interface framebuffer_reader_if #(
  parameter int WIDTH = 16,
  parameter int H_RES = 160,
  parameter int V_RES = 120
);
  localparam int DEPTH      = H_RES * V_RES;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int XW         = $clog2(H_RES);
  localparam int YW         = $clog2(V_RES);

  logic [ADDR_WIDTH-1:0] addr_read;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      pixel_data;
  logic [XW-1:0]         pixel_x;
  logic [YW-1:0]         pixel_y;
  logic                  pixel_last;
  logic                  frame_last;
  logic                  pixel_valid;
  logic                  pixel_ready;

  modport master (
    output addr_read,
    input  data_in,
    output pixel_data, pixel_x, pixel_y, pixel_last, frame_last, pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  addr_read,
    output data_in,
    input  pixel_data, pixel_x, pixel_y, pixel_last, frame_last, pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/framebuffer_reader.sv
// Raster scan of the framebuffer read port into a tagged valid/ready pixel stream.
// First pixel 2 cycles after the scan starts, then 1/cycle; reads throttle so in-flight + buffered <= 2.
module framebuffer_reader #(
  parameter int WIDTH = 16,
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 buf_ready,
  output logic                 busy,
  output logic                 done,
  framebuffer_reader_if.master fb
);
  localparam int DEPTH      = H_RES * V_RES;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int XW         = $clog2(H_RES);
  localparam int YW         = $clog2(V_RES);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(H_RES - 1);
  localparam logic [YW-1:0]         LAST_Y    = YW'(V_RES - 1);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          pix_last;
    logic          frm_last;
  } tag_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    tag_t             tag;
  } pix_t;

  typedef enum logic [1:0] {IDLE, WAIT_READY, READING, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic                  inflight_vld;
  tag_t                  inflight_tag;
  pix_t                  fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_cnt;

  logic       pop;
  logic       issue;
  logic [1:0] occ_next;
  pix_t       head;

  assign head = fifo_mem[rd_ptr];
  assign pop  = (fifo_cnt != 2'd0) && fb.pixel_ready;
  // FIFO occupancy after this edge, counting the read whose data lands now
  assign occ_next = fifo_cnt + {1'b0, inflight_vld} - {1'b0, pop};
  assign issue    = (state == READING) && (occ_next < 2'd2);

  assign fb.addr_read   = rd_addr;
  assign fb.pixel_valid = (fifo_cnt != 2'd0);
  assign fb.pixel_data  = head.data;
  assign fb.pixel_x     = head.tag.x;
  assign fb.pixel_y     = head.tag.y;
  assign fb.pixel_last  = head.tag.pix_last;
  assign fb.frame_last  = head.tag.frm_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_READY;
            busy    <= 1'b1;
            rd_addr <= '0;
          end
        end
        WAIT_READY: begin
          if (buf_ready) begin
            state   <= READING;
            rd_addr <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
          end
        end
        READING: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
            if (x_cnt == LAST_X) begin
              x_cnt <= '0;
              y_cnt <= (y_cnt == LAST_Y) ? '0 : y_cnt + 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Final pixel leaving an otherwise empty pipeline ends the frame
          if (pop && head.tag.frm_last && (fifo_cnt == 2'd1) && !inflight_vld) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_vld <= 1'b0;
      inflight_tag <= '0;
      fifo_mem[0]  <= '0;
      fifo_mem[1]  <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      inflight_vld <= issue;
      if (issue) begin
        inflight_tag <= '{x: x_cnt, y: y_cnt, pix_last: (x_cnt == LAST_X),
                          frm_last: (x_cnt == LAST_X) && (y_cnt == LAST_Y)};
      end
      if (inflight_vld) begin
        fifo_mem[wr_ptr] <= '{data: fb.data_in, tag: inflight_tag};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= occ_next;
    end
  end
endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench: a 4x2 instance for directed scenarios and a 160x120 instance for a full default frame.
module tb_framebuffer_reader;
  localparam int SH = 4;
  localparam int SV = 2;
  localparam int SD = SH * SV;
  localparam int BH = 160;
  localparam int BV = 120;
  localparam int BD = BH * BV;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic s_start = 1'b0, s_buf_ready = 1'b0, s_busy, s_done;
  logic b_start = 1'b0, b_buf_ready = 1'b0, b_busy, b_done;

  framebuffer_reader_if #(.WIDTH(16), .H_RES(SH), .V_RES(SV)) s_if ();
  framebuffer_reader_if #(.WIDTH(16), .H_RES(BH), .V_RES(BV)) b_if ();

  framebuffer_reader #(.WIDTH(16), .H_RES(SH), .V_RES(SV)) u_small (
    .clk(clk), .rstn(rstn), .start(s_start), .buf_ready(s_buf_ready),
    .busy(s_busy), .done(s_done), .fb(s_if)
  );

  framebuffer_reader #(.WIDTH(16), .H_RES(BH), .V_RES(BV)) u_big (
    .clk(clk), .rstn(rstn), .start(b_start), .buf_ready(b_buf_ready),
    .busy(b_busy), .done(b_done), .fb(b_if)
  );

  // Synchronous-read memories: small holds value = address, big holds address ^ 5a5a
  always @(posedge clk) s_if.data_in <= 16'(s_if.addr_read);
  always @(posedge clk) b_if.data_in <= 16'(b_if.addr_read) ^ 16'h5a5a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: next expected raster index, expected busy/done, observed done pulses
  int s_idx = 0, b_idx = 0;
  bit s_busy_m = 0, s_done_m = 0, b_busy_m = 0, b_done_m = 0;
  int s_done_cnt = 0, b_done_cnt = 0;
  bit bp_phase = 0;
  logic [14:0] b_last_xy = '0;

  always @(negedge clk) begin
    bit busy_now;
    if (!rstn) begin
      s_idx = 0; s_busy_m = 0; s_done_m = 0;
      chk("s_reset_outputs", {s_if.pixel_valid, s_busy, s_done, s_if.addr_read}, '0);
    end else begin
      busy_now = s_busy_m;
      chk("s_busy", s_busy, s_busy_m);
      chk("s_done", s_done, s_done_m);
      if (s_done) s_done_cnt++;
      s_done_m = 0;
      if (bp_phase && busy_now && (int'(s_if.addr_read) != SD - 1))
        chk("s_outstanding_le2", (int'(s_if.addr_read) - s_idx) <= 2, 1);
      if (s_if.pixel_valid) begin
        if (!busy_now || s_idx >= SD) begin
          chk("s_unexpected_valid", 1, 0);
        end else begin
          chk("s_pixel", {s_if.pixel_data, s_if.pixel_x, s_if.pixel_y,
                          s_if.pixel_last, s_if.frame_last},
              {16'(s_idx), 2'(s_idx % SH), 1'(s_idx / SH),
               (s_idx % SH) == SH - 1, s_idx == SD - 1});
          if (s_if.pixel_ready) begin
            if (s_idx == SD - 1) begin
              s_done_m = 1;
              s_busy_m = 0;
            end
            s_idx++;
          end
        end
      end
      if (s_start && !busy_now) begin
        s_busy_m = 1;
        s_idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit busy_now;
    if (!rstn) begin
      b_idx = 0; b_busy_m = 0; b_done_m = 0;
      chk("b_reset_outputs", {b_if.pixel_valid, b_busy, b_done}, '0);
    end else begin
      busy_now = b_busy_m;
      chk("b_busy", b_busy, b_busy_m);
      chk("b_done", b_done, b_done_m);
      if (b_done) b_done_cnt++;
      b_done_m = 0;
      if (b_if.pixel_valid) begin
        if (!busy_now || b_idx >= BD) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          chk("b_pixel", {b_if.pixel_data, b_if.pixel_x, b_if.pixel_y,
                          b_if.pixel_last, b_if.frame_last},
              {16'(b_idx) ^ 16'h5a5a, 8'(b_idx % BH), 7'(b_idx / BH),
               (b_idx % BH) == BH - 1, b_idx == BD - 1});
          if (b_if.frame_last) b_last_xy = {b_if.pixel_x, b_if.pixel_y};
          if (b_if.pixel_ready) begin
            if (b_idx == BD - 1) begin
              b_done_m = 1;
              b_busy_m = 0;
            end
            b_idx++;
          end
        end
      end
      if (b_start && !busy_now) begin
        b_busy_m = 1;
        b_idx = 0;
      end
    end
  end

  bit [3:0] pat = 4'b1001;

  // Runs the small instance until a new done pulse or the cycle budget expires
  task automatic wait_s(input int bound, input bit toggle, input string name);
    int n0 = s_done_cnt;
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      s_if.pixel_ready = toggle ? pat[i % 4] : 1'b1;
      if (s_done_cnt != n0) begin
        seen = 1;
        break;
      end
      tick();
    end
    s_if.pixel_ready = 1'b1;
    chk(name, seen, 1);
  endtask

  initial begin
    int lat;
    int hs;
    int d0;
    s_if.pixel_ready = 1'b0;
    b_if.pixel_ready = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("reset_idle_state", {s_busy, s_done, s_if.pixel_valid, s_if.addr_read}, '0);

    // Basic frame with continuous ready
    s_buf_ready = 1'b1;
    s_if.pixel_ready = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (s_if.pixel_valid) begin
        lat = i;
        break;
      end
    end
    chk("basic_first_valid_latency", lat, 4);
    for (int k = 0; k < SD; k++) begin
      if (k > 0) @(negedge clk);
      chk("basic_pixel_seq", {s_if.pixel_valid, s_if.pixel_data}, {1'b1, 16'(k)});
      if (k == 3) chk("basic_line_last", {s_if.pixel_last, s_if.frame_last}, 2'b10);
      if (k == 7) chk("basic_frame_last",
                      {s_if.pixel_last, s_if.frame_last, s_if.pixel_x, s_if.pixel_y}, 5'b11111);
    end
    @(negedge clk);
    chk("basic_done_pulse", {s_done, s_busy}, 2'b10);
    @(negedge clk);
    chk("basic_done_single", {s_done, s_busy}, 2'b00);
    tick();

    // Backpressure 1,0,0,1
    bp_phase = 1;
    s_start = 1'b1;
    s_if.pixel_ready = pat[0];
    tick();
    s_start = 1'b0;
    wait_s(200, 1'b1, "bp_done_seen");
    bp_phase = 0;
    tick();

    // Start while the buffer is clearing
    s_buf_ready = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("clear_wait_idle", {s_if.addr_read, s_if.pixel_valid, s_busy}, 5'b00001);
      tick();
    end
    s_buf_ready = 1'b1;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_if.pixel_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("clear_first_valid_latency", lat, 3);
    tick();
    wait_s(100, 1'b0, "clear_done_seen");
    tick();

    // Second start mid-frame is ignored
    d0 = s_done_cnt;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (5) tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (30) tick();
    chk("busy_start_one_done", s_done_cnt - d0, 1);

    // Reset after three pixels
    d0 = s_done_cnt;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    hs = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      @(negedge clk);
      if (s_if.pixel_valid && s_if.pixel_ready) hs++;
      tick();
    end
    chk("rst_three_pixels", hs, 3);
    rstn = 1'b0;
    #1;
    chk("rst_async_outputs",
        {s_if.pixel_valid, s_if.pixel_data, s_if.pixel_x, s_if.pixel_y, s_if.pixel_last,
         s_if.frame_last, s_if.addr_read, s_busy, s_done}, '0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("rst_no_done", s_done_cnt - d0, 0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (s_if.pixel_valid) begin
        lat = i;
        break;
      end
    end
    chk("rst_restart_pixel0", {lat[3:0], s_if.pixel_data, s_if.pixel_x, s_if.pixel_y},
        {4'd4, 16'd0, 2'd0, 1'b0});
    tick();
    wait_s(100, 1'b0, "rst_restart_done");
    tick();

    // Full default-size frame
    b_buf_ready = 1'b1;
    b_if.pixel_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < BD + 100 && b_done_cnt == 0; i++) tick();
    chk("big_done_count", b_done_cnt, 1);
    chk("big_pixel_total", b_idx, BD);
    chk("big_last_xy", b_last_xy, {8'd159, 7'd119});
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
